// File: rtl/mips_core_pkg.sv
// Shared types and sizes for the MIPS out-of-order core.
// Covers the rename state, the free-list pointers and the branch checkpoints.
package mips_core_pkg;

    localparam int NUM_ARCH   = 32;
    localparam int NUM_PHYS   = 64;
    localparam int NUM_CKPT   = 4;
    localparam int FL_PTR_W   = 7;
    localparam int CKPT_PTR_W = 3;

    typedef logic [4:0]            ArchReg;
    typedef logic [5:0]            PhysReg;
    typedef logic [FL_PTR_W-1:0]   FlPtr;
    typedef logic [CKPT_PTR_W-1:0] CkptPtr;

    typedef struct packed {
        PhysReg [NUM_ARCH-1:0] rat;
        FlPtr                  head;
    } ckpt_t;

    // Rebuild a full wrap-tagged pointer from a 2-bit slot index. A slot
    // below the oldest slot's index has wrapped once relative to head.
    function automatic CkptPtr ckpt_ptr_from_entry(input CkptPtr head, input logic [1:0] entry);
        return {head[2] ^ (entry < head[1:0]), entry};
    endfunction

endpackage

// File: rtl/reg_rename_phys_free_list.sv
// Circular FIFO of free physical registers: pop on allocate, push on retire,
// and head rewind on mispredict restore.
module phys_free_list
    import mips_core_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   alloc,
    input  logic   free,
    input  PhysReg free_phys,
    input  logic   restore,
    input  FlPtr   restore_head,
    output PhysReg head_phys,
    output FlPtr   head,
    output FlPtr   count
);

    PhysReg fifo [NUM_PHYS];
    FlPtr   tail;

    assign head_phys = fifo[head[5:0]];
    assign count     = tail - head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                fifo[i] <= (i < NUM_ARCH) ? PhysReg'(i + NUM_ARCH) : '0;
            end
            head <= '0;
            tail <= FlPtr'(NUM_ARCH);
        end else begin
            if (restore) begin
                head <= restore_head;
            end else if (alloc) begin
                head <= head + FlPtr'(1);
            end
            if (free) begin
                fifo[tail[5:0]] <= free_phys;
                tail            <= tail + FlPtr'(1);
            end
        end
    end

    // Only 32 registers can ever be free at once; more means a double free.
    assert property (@(posedge clk) disable iff (!rst_n)
        (free && !alloc && !restore) |-> (count < FlPtr'(NUM_ARCH)));
    assert property (@(posedge clk) disable iff (!rst_n)
        free |-> (free_phys != '0));

endmodule

// File: rtl/reg_rename.sv
// Rename stage: speculative and committed RATs, free-list allocation,
// per-physical ready bits and four branch checkpoints.
module reg_rename
    import mips_core_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rename_valid,
    input  logic [4:0]          rs_arch,
    input  logic [4:0]          rt_arch,
    input  logic [4:0]          rw_arch,
    input  logic                uses_rw,
    input  logic                is_branch,
    output logic                rename_ready,
    output logic [5:0]          rs_phys,
    output logic [5:0]          rt_phys,
    output logic [5:0]          rw_phys,
    input  logic                wb_valid,
    input  logic [5:0]          wb_phys,
    output logic [NUM_PHYS-1:0] reg_ready,
    input  logic                retire_valid,
    input  logic                retire_uses_rw,
    input  logic [4:0]          retire_rw_arch,
    input  logic [5:0]          retire_rw_phys,
    input  logic                ckpt_restore,
    input  logic [1:0]          ckpt_entry,
    input  logic                ckpt_release
);

    PhysReg [NUM_ARCH-1:0] rat_q;
    PhysReg [NUM_ARCH-1:0] rat_next;
    PhysReg [NUM_ARCH-1:0] crat_q;
    ckpt_t                 ckpt_q [NUM_CKPT];
    CkptPtr                ckpt_head_q;
    CkptPtr                ckpt_tail_q;
    CkptPtr                ckpt_count;

    logic   need_alloc;
    logic   fire;
    logic   do_alloc;
    logic   take_ckpt;
    logic   do_free;
    PhysReg free_phys;
    PhysReg fl_head_phys;
    FlPtr   fl_head;
    FlPtr   fl_count;

    assign need_alloc   = uses_rw && (rw_arch != '0);
    assign ckpt_count   = ckpt_tail_q - ckpt_head_q;
    assign rename_ready = !ckpt_restore
                       && (!need_alloc || (fl_count != '0))
                       && (!is_branch  || (ckpt_count < CkptPtr'(NUM_CKPT)));
    assign fire         = rename_valid && rename_ready;
    assign do_alloc     = fire && need_alloc;
    assign take_ckpt    = fire && is_branch;

    // Sources read the pre-rename map, so rs == rw sees the old producer.
    assign rs_phys = rat_q[rs_arch];
    assign rt_phys = rat_q[rt_arch];
    assign rw_phys = need_alloc ? fl_head_phys : rat_q[rw_arch];

    assign do_free   = retire_valid && retire_uses_rw && (retire_rw_arch != '0);
    assign free_phys = crat_q[retire_rw_arch];

    always_comb begin
        rat_next = rat_q;
        if (do_alloc) begin
            rat_next[rw_arch] = fl_head_phys;
        end
    end

    phys_free_list u_free_list (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc        (do_alloc),
        .free         (do_free),
        .free_phys    (free_phys),
        .restore      (ckpt_restore),
        .restore_head (ckpt_q[ckpt_entry].head),
        .head_phys    (fl_head_phys),
        .head         (fl_head),
        .count        (fl_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                rat_q[i]  <= PhysReg'(i);
                crat_q[i] <= PhysReg'(i);
            end
            ckpt_head_q <= '0;
            ckpt_tail_q <= '0;
            reg_ready   <= '1;
        end else begin
            if (ckpt_restore) begin
                rat_q       <= ckpt_q[ckpt_entry].rat;
                ckpt_tail_q <= ckpt_ptr_from_entry(ckpt_head_q, ckpt_entry);
            end else begin
                rat_q <= rat_next;
                if (take_ckpt) begin
                    ckpt_tail_q <= ckpt_tail_q + CkptPtr'(1);
                end
            end
            if (ckpt_release && (ckpt_count != '0)) begin
                ckpt_head_q <= ckpt_head_q + CkptPtr'(1);
            end
            if (do_free) begin
                crat_q[retire_rw_arch] <= retire_rw_phys;
            end
            if (wb_valid && (wb_phys != '0)) begin
                reg_ready[wb_phys] <= 1'b1;
            end
            if (do_alloc) begin
                reg_ready[fl_head_phys] <= 1'b0;
            end
        end
    end

    // Snapshot holds the map and free-list head as they stand after this rename.
    always_ff @(posedge clk) begin
        if (take_ckpt) begin
            ckpt_q[ckpt_tail_q[1:0]].rat  <= rat_next;
            ckpt_q[ckpt_tail_q[1:0]].head <= fl_head + (do_alloc ? FlPtr'(1) : FlPtr'(0));
        end
    end

endmodule

// File: tb/tb_reg_rename.sv
// Directed bench for reg_rename: hand-computed mappings, exhaustion,
// restore, checkpoint limit and asynchronous reset.
module tb_reg_rename;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rename_valid;
    logic [4:0]  rs_arch, rt_arch, rw_arch;
    logic        uses_rw, is_branch;
    logic        rename_ready;
    logic [5:0]  rs_phys, rt_phys, rw_phys;
    logic        wb_valid;
    logic [5:0]  wb_phys;
    logic [63:0] reg_ready;
    logic        retire_valid, retire_uses_rw;
    logic [4:0]  retire_rw_arch;
    logic [5:0]  retire_rw_phys;
    logic        ckpt_restore;
    logic [1:0]  ckpt_entry;
    logic        ckpt_release;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_rename dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rename_valid   (rename_valid),
        .rs_arch        (rs_arch),
        .rt_arch        (rt_arch),
        .rw_arch        (rw_arch),
        .uses_rw        (uses_rw),
        .is_branch      (is_branch),
        .rename_ready   (rename_ready),
        .rs_phys        (rs_phys),
        .rt_phys        (rt_phys),
        .rw_phys        (rw_phys),
        .wb_valid       (wb_valid),
        .wb_phys        (wb_phys),
        .reg_ready      (reg_ready),
        .retire_valid   (retire_valid),
        .retire_uses_rw (retire_uses_rw),
        .retire_rw_arch (retire_rw_arch),
        .retire_rw_phys (retire_rw_phys),
        .ckpt_restore   (ckpt_restore),
        .ckpt_entry     (ckpt_entry),
        .ckpt_release   (ckpt_release)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rename_valid = 0; rs_arch = 0; rt_arch = 0; rw_arch = 0;
        uses_rw = 0; is_branch = 0; wb_valid = 0; wb_phys = 0;
        retire_valid = 0; retire_uses_rw = 0; retire_rw_arch = 0; retire_rw_phys = 0;
        ckpt_restore = 0; ckpt_entry = 0; ckpt_release = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                           input logic uw, input logic br);
        rename_valid = 1; rs_arch = rs; rt_arch = rt; rw_arch = rw;
        uses_rw = uw; is_branch = br;
    endtask

    initial begin
        do_reset();

        // 1: identity map after reset
        present(5'd5, 5'd0, 5'd0, 0, 0);
        #1;
        check("rst_rs", 64'(rs_phys), 64'd5);
        check("rst_rt", 64'(rt_phys), 64'd0);
        check("rst_ready_vec", reg_ready, {64{1'b1}});
        check("rst_rename_ready", 64'(rename_ready), 64'd1);

        // 2: first allocation, bypass of pre-rename mapping, writeback
        present(5'd3, 5'd0, 5'd3, 1, 0);
        #1;
        check("alloc_rw", 64'(rw_phys), 64'd32);
        check("alloc_rs_old", 64'(rs_phys), 64'd3);
        tick(); idle();
        check("alloc_notready", 64'(reg_ready[32]), 64'd0);
        present(5'd3, 5'd0, 5'd0, 0, 0);
        #1;
        check("renamed_rs", 64'(rs_phys), 64'd32);
        tick(); idle();
        wb_valid = 1; wb_phys = 6'd32;
        tick(); idle();
        check("wb_ready", 64'(reg_ready[32]), 64'd1);

        // 3: exhaust the free list, then refill by retire
        for (int i = 0; i < 31; i++) begin
            present(5'd0, 5'd0, 5'd4, 1, 0);
            tick();
        end
        idle();
        present(5'd0, 5'd0, 5'd5, 1, 0);
        #1;
        check("exhaust_blocked", 64'(rename_ready), 64'd0);
        present(5'd0, 5'd0, 5'd0, 1, 0);
        #1;
        check("exhaust_zero_ok", 64'(rename_ready), 64'd1);
        check("exhaust_zero_phys", 64'(rw_phys), 64'd0);
        idle();
        retire_valid = 1; retire_uses_rw = 1; retire_rw_arch = 5'd3; retire_rw_phys = 6'd32;
        tick(); idle();
        present(5'd0, 5'd0, 5'd5, 1, 0);
        #1;
        check("refill_ready", 64'(rename_ready), 64'd1);
        check("refill_rw", 64'(rw_phys), 64'd3);
        idle();

        // 4: mispredict restore
        do_reset();
        present(5'd0, 5'd0, 5'd1, 1, 0);
        tick();
        present(5'd0, 5'd0, 5'd0, 0, 1);
        tick();
        present(5'd0, 5'd0, 5'd1, 1, 0);
        #1;
        check("spec_r1", 64'(rw_phys), 64'd33);
        tick();
        present(5'd0, 5'd0, 5'd2, 1, 0);
        #1;
        check("spec_r2", 64'(rw_phys), 64'd34);
        tick(); idle();
        present(5'd0, 5'd0, 5'd6, 1, 0);
        ckpt_restore = 1; ckpt_entry = 2'd0;
        #1;
        check("restore_blocks", 64'(rename_ready), 64'd0);
        tick(); idle();
        present(5'd1, 5'd2, 5'd5, 1, 0);
        #1;
        check("restore_r1", 64'(rs_phys), 64'd32);
        check("restore_r2", 64'(rt_phys), 64'd2);
        check("restore_alloc", 64'(rw_phys), 64'd33);
        idle();

        // 5: checkpoint limit and release
        do_reset();
        for (int i = 0; i < 4; i++) begin
            present(5'd0, 5'd0, 5'd0, 0, 1);
            tick();
        end
        present(5'd0, 5'd0, 5'd0, 0, 1);
        #1;
        check("ckpt_full", 64'(rename_ready), 64'd0);
        present(5'd0, 5'd0, 5'd7, 1, 0);
        #1;
        check("ckpt_full_nonbr", 64'(rename_ready), 64'd1);
        tick(); idle();
        ckpt_release = 1;
        tick(); idle();
        present(5'd0, 5'd0, 5'd0, 0, 1);
        #1;
        check("ckpt_released", 64'(rename_ready), 64'd1);
        tick(); idle();

        // 6: asynchronous reset mid-operation
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            present(5'd0, 5'd0, 5'(i), 1, 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            present(5'd0, 5'd0, 5'd0, 0, 1);
            tick();
        end
        idle();
        present(5'd1, 5'd0, 5'd7, 1, 1);
        #1;
        check("pre_rst_rs", 64'(rs_phys), 64'd32);
        check("pre_rst_notready", 64'(reg_ready[41]), 64'd0);
        rst_n = 0;
        #1;
        check("arst_rs", 64'(rs_phys), 64'd1);
        check("arst_rw", 64'(rw_phys), 64'd32);
        check("arst_ready_vec", reg_ready, {64{1'b1}});
        check("arst_rename_ready", 64'(rename_ready), 64'd1);
        idle();
        tick();
        rst_n = 1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
